// File: rtl/pixel_filter_axil_if.sv
// Register-bus and pixel-stream bundles for pixel_filter_axil.
// Each bundle has master/slave modports.
interface pixel_filter_axil_if #(
   parameter int AW = 4,
   parameter int DW = 32
);
   logic [AW-1:0]   AWADDR;
   logic [2:0]      AWPROT;
   logic            AWVALID;
   logic            AWREADY;
   logic [DW-1:0]   WDATA;
   logic [DW/8-1:0] WSTRB;
   logic            WVALID;
   logic            WREADY;
   logic [1:0]      BRESP;
   logic            BVALID;
   logic            BREADY;
   logic [AW-1:0]   ARADDR;
   logic [2:0]      ARPROT;
   logic            ARVALID;
   logic            ARREADY;
   logic [DW-1:0]   RDATA;
   logic [1:0]      RRESP;
   logic            RVALID;
   logic            RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID,
      output BREADY, ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID,
      input  ARREADY, RDATA, RRESP, RVALID
   );
   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID,
      input  BREADY, ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID,
      output ARREADY, RDATA, RRESP, RVALID
   );
endinterface

interface pixel_stream_if #(
   parameter int W = 24
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;

   modport master (output tdata, tvalid, tlast, input tready);
   modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/pixel_filter_axil.sv
// Run-time configurable per-channel pixel filter with a four-register
// AXI4-Lite slave and a one-stage registered stream pipeline.
module pixel_filter_axil #(
   parameter int NUM_CHANNELS       = 3,
   parameter int CHANNEL_WIDTH      = 8,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic           ACLK,
   input  logic           ARESETN,
   pixel_filter_axil_if.slave s_axil,
   pixel_stream_if.slave  s_axis,
   pixel_stream_if.master m_axis
);
   localparam int NC = NUM_CHANNELS;
   localparam int CW = CHANNEL_WIDTH;
   localparam int PW = NC * CW;

   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_MASK = 2'd1;
   localparam logic [1:0] A_THR  = 2'd2;
   localparam logic [1:0] A_CNT  = 2'd3;

   localparam logic [1:0] M_MASK = 2'd0;
   localparam logic [1:0] M_THR  = 2'd1;
   localparam logic [1:0] M_INV  = 2'd2;
   localparam logic [1:0] M_DOM  = 2'd3;

   logic          r_run;
   logic          r_en;
   logic [1:0]    r_mode;
   logic [NC-1:0] r_mask;
   logic [CW-1:0] r_thr;
   logic [31:0]   r_cnt;
   logic          r_bvalid;
   logic          r_rvalid;
   logic [31:0]   r_rdata;
   logic          r_mvalid;
   logic [PW-1:0] r_mdata;
   logic          r_mlast;

   logic          w_wr;
   logic          w_rd;
   logic          w_sready;
   logic          w_sacc;
   logic          w_mhs;
   logic [31:0]   w_regs [4];
   logic [31:0]   w_bmask;
   logic [31:0]   w_new;
   logic [NC-1:0] w_top;
   logic [PW-1:0] w_filt;
   logic          w_unused;

   // r_run keeps every handshake output low until the first edge after reset
   assign w_wr = r_run & s_axil.AWVALID & s_axil.WVALID & ~r_bvalid;
   assign w_rd = r_run & s_axil.ARVALID & ~r_rvalid;
   assign w_sready = r_run & (~r_mvalid | m_axis.tready);
   assign w_sacc = s_axis.tvalid & w_sready;
   assign w_mhs = r_mvalid & m_axis.tready;

   always_comb begin
      w_regs[0] = {29'd0, r_mode, r_en};
      w_regs[1] = 32'(r_mask);
      w_regs[2] = 32'(r_thr);
      w_regs[3] = r_cnt;
   end

   always_comb begin
      w_bmask = '0;
      for (int b = 0; b < 4; b++) begin
         w_bmask[b*8 +: 8] = {8{s_axil.WSTRB[b]}};
      end
   end

   assign w_new = (w_regs[s_axil.AWADDR[3:2]] & ~w_bmask)
                | (s_axil.WDATA & w_bmask);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_en   <= 1'b0;
         r_mode <= 2'd0;
         r_mask <= '1;
         r_thr  <= '0;
      end else if (w_wr) begin
         unique case (s_axil.AWADDR[3:2])
            A_CTRL: begin
               r_en   <= w_new[0];
               r_mode <= w_new[2:1];
            end
            A_MASK: r_mask <= w_new[NC-1:0];
            A_THR:  r_thr  <= w_new[CW-1:0];
            default: ;
         endcase
      end
   end

   // A clear request outranks a same-cycle increment
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_cnt <= '0;
      end else if (w_wr && s_axil.AWADDR[3:2] == A_CNT) begin
         r_cnt <= '0;
      end else if (w_mhs) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_run    <= 1'b0;
         r_bvalid <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_run <= 1'b1;
         if (w_wr) begin
            r_bvalid <= 1'b1;
         end else if (s_axil.BREADY) begin
            r_bvalid <= 1'b0;
         end
         if (w_rd) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_regs[s_axil.ARADDR[3:2]];
         end else if (s_axil.RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_top = '1;
      for (int i = 0; i < NC; i++) begin
         for (int j = 0; j < NC; j++) begin
            if (i != j && s_axis.tdata[i*CW +: CW] <= s_axis.tdata[j*CW +: CW]) begin
               w_top[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_filt = s_axis.tdata;
      if (r_en) begin
         for (int c = 0; c < NC; c++) begin
            unique case (r_mode)
               M_MASK: begin
                  if (!r_mask[c]) w_filt[c*CW +: CW] = '0;
               end
               M_THR: begin
                  if (!r_mask[c] || s_axis.tdata[c*CW +: CW] < r_thr) begin
                     w_filt[c*CW +: CW] = '0;
                  end
               end
               M_INV: begin
                  if (r_mask[c]) w_filt[c*CW +: CW] = ~s_axis.tdata[c*CW +: CW];
               end
               M_DOM: begin
                  if (!(r_mask[c] && w_top[c])) w_filt[c*CW +: CW] = '0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_mvalid <= 1'b0;
         r_mdata  <= '0;
         r_mlast  <= 1'b0;
      end else if (w_sacc) begin
         r_mvalid <= 1'b1;
         r_mdata  <= w_filt;
         r_mlast  <= s_axis.tlast;
      end else if (m_axis.tready) begin
         r_mvalid <= 1'b0;
      end
   end

   assign s_axil.AWREADY = w_wr;
   assign s_axil.WREADY  = w_wr;
   assign s_axil.BRESP   = 2'b00;
   assign s_axil.BVALID  = r_bvalid;
   assign s_axil.ARREADY = w_rd;
   assign s_axil.RDATA   = r_rdata;
   assign s_axil.RRESP   = 2'b00;
   assign s_axil.RVALID  = r_rvalid;

   assign s_axis.tready = w_sready;
   assign m_axis.tvalid = r_mvalid;
   assign m_axis.tdata  = r_mdata;
   assign m_axis.tlast  = r_mlast;

   assign w_unused = ^{s_axil.AWADDR[1:0], s_axil.ARADDR[1:0],
                       s_axil.AWPROT, s_axil.ARPROT, w_new};
endmodule

// File: tb/tb_pixel_filter_axil.sv
// Scoreboard bench for pixel_filter_axil: directed register and
// pixel vectors, decoupled R-channel and stream monitors.
module tb_pixel_filter_axil;
   localparam int NC = 3;
   localparam int CW = 8;
   localparam int PW = NC * CW;

   logic ACLK = 1'b0;
   logic ARESETN = 1'b0;

   pixel_filter_axil_if axil ();
   pixel_stream_if #(.W(PW)) sin ();
   pixel_stream_if #(.W(PW)) mout ();

   pixel_filter_axil #(
      .NUM_CHANNELS(NC),
      .CHANNEL_WIDTH(CW),
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4)
   ) dut (
      .ACLK(ACLK),
      .ARESETN(ARESETN),
      .s_axil(axil),
      .s_axis(sin),
      .m_axis(mout)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp = 0;
   int n_err = 0;
   int b_hs = 0;
   logic [31:0] rq[$];
   logic [PW:0] sq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, got no response expected one", nm);
   endtask

   always @(negedge ACLK) begin
      if (ARESETN && axil.RVALID && axil.RREADY) begin
         if (rq.size() == 0) tmo("rd_unexpected");
         else begin
            chk("rdata", axil.RDATA, rq.pop_front());
            chk("rresp", 32'(axil.RRESP), 32'd0);
         end
      end
   end

   always @(negedge ACLK) begin
      if (ARESETN && axil.BVALID && axil.BREADY) b_hs++;
   end

   // Stalled beats are checked against the head entry every cycle
   always @(negedge ACLK) begin
      if (ARESETN && mout.tvalid) begin
         if (sq.size() == 0) tmo("px_unexpected");
         else begin
            chk("px_data", 32'(mout.tdata), 32'(sq[0][PW-1:0]));
            chk("px_last", 32'(mout.tlast), 32'(sq[0][PW]));
            if (mout.tready) void'(sq.pop_front());
         end
      end
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      int n;
      axil.AWADDR = a;
      axil.WDATA = d;
      axil.WSTRB = s;
      axil.AWVALID = 1'b1;
      axil.WVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!axil.AWREADY && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      if (!axil.AWREADY) tmo("wr_accept");
      @(posedge ACLK);
      #1;
      axil.AWVALID = 1'b0;
      axil.WVALID = 1'b0;
      n = 0;
      @(negedge ACLK);
      while (!axil.BVALID && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      if (!axil.BVALID) tmo("wr_bvalid");
      @(posedge ACLK);
      #1;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      int n;
      rq.push_back(exp);
      axil.ARADDR = a;
      axil.ARVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!axil.ARREADY && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      if (!axil.ARREADY) tmo("rd_accept");
      @(posedge ACLK);
      #1;
      axil.ARVALID = 1'b0;
      @(posedge ACLK);
      #1;
   endtask

   task automatic px(input logic [PW-1:0] d, input logic l,
                     input logic [PW-1:0] exp);
      int n;
      sq.push_back({l, exp});
      sin.tdata = d;
      sin.tlast = l;
      sin.tvalid = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!sin.tready && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      if (!sin.tready) tmo("px_accept");
      @(posedge ACLK);
      #1;
      sin.tvalid = 1'b0;
      sin.tlast = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sq.size() != 0 && n < 60) begin
         @(posedge ACLK);
         n++;
      end
      #1;
      if (sq.size() != 0) tmo("px_drain");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b0;
      int n;
      logic [PW-1:0] d;
      axil.AWADDR = '0;
      axil.AWPROT = '0;
      axil.AWVALID = 1'b0;
      axil.WDATA = '0;
      axil.WSTRB = '0;
      axil.WVALID = 1'b0;
      axil.BREADY = 1'b1;
      axil.ARADDR = '0;
      axil.ARPROT = '0;
      axil.ARVALID = 1'b0;
      axil.RREADY = 1'b1;
      sin.tdata = '0;
      sin.tvalid = 1'b0;
      sin.tlast = 1'b0;
      mout.tready = 1'b1;

      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_s_tready", 32'(sin.tready), 32'd0);
      chk("rst_m_tvalid", 32'(mout.tvalid), 32'd0);
      chk("rst_bvalid", 32'(axil.BVALID), 32'd0);
      chk("rst_rvalid", 32'(axil.RVALID), 32'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(posedge ACLK);
      #1;
      chk("rel_s_tready", 32'(sin.tready), 32'd1);

      rd(4'h0, 32'h0);
      rd(4'h4, 32'h7);
      rd(4'h8, 32'h0);
      rd(4'hC, 32'h0);

      wr(4'h0, 32'h5, 4'hF);
      wr(4'h4, 32'h6, 4'hF);
      wr(4'h8, 32'h80, 4'hF);
      rd(4'h0, 32'h5);
      rd(4'h4, 32'h6);
      rd(4'h8, 32'h80);
      wr(4'h4, 32'hFF, 4'h0);
      rd(4'h4, 32'h6);

      b0 = b_hs;
      axil.AWADDR = 4'h8;
      axil.WDATA = 32'h55;
      axil.WSTRB = 4'hF;
      axil.AWVALID = 1'b1;
      repeat (3) begin
         @(negedge ACLK);
         chk("aw_alone_rdy", 32'(axil.AWREADY), 32'd0);
         chk("aw_alone_b", 32'(axil.BVALID), 32'd0);
      end
      @(posedge ACLK);
      #1;
      axil.WVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!axil.AWREADY && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      if (!axil.AWREADY) tmo("aw_early_accept");
      @(posedge ACLK);
      #1;
      axil.AWVALID = 1'b0;
      axil.WVALID = 1'b0;
      repeat (4) @(posedge ACLK);
      #1;
      chk("aw_early_bcount", 32'(b_hs - b0), 32'd1);
      rd(4'h8, 32'h55);

      wr(4'h0, 32'h1, 4'hF);
      wr(4'h4, 32'h4, 4'hF);
      px(24'h302010, 1'b0, 24'h300000);
      drain();
      wr(4'h0, 32'h0, 4'hF);
      px(24'h302010, 1'b1, 24'h302010);
      drain();

      wr(4'h0, 32'h3, 4'hF);
      wr(4'h4, 32'h7, 4'hF);
      wr(4'h8, 32'h20, 4'hF);
      px(24'h30201F, 1'b0, 24'h302000);
      drain();
      wr(4'h0, 32'h5, 4'hF);
      wr(4'h4, 32'h1, 4'hF);
      px(24'h302010, 1'b1, 24'h3020EF);
      drain();

      wr(4'h0, 32'h7, 4'hF);
      wr(4'h4, 32'h7, 4'hF);
      px(24'h109040, 1'b0, 24'h009000);
      px(24'h909040, 1'b1, 24'h000000);
      drain();

      wr(4'h0, 32'h0, 4'hF);
      wr(4'hC, 32'h0, 4'hF);
      rd(4'hC, 32'h0);
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               d = {8'(i), 8'(~i), 8'(8'hA5 ^ i)};
               px(d, i == 15, d);
            end
         end
         begin
            repeat (44) begin
               @(posedge ACLK);
               #1;
               mout.tready = ~mout.tready;
            end
         end
      join
      mout.tready = 1'b1;
      drain();
      rd(4'hC, 32'd16);

      mout.tready = 1'b0;
      px(24'h111111, 1'b0, 24'h111111);
      axil.AWADDR = 4'hC;
      axil.WDATA = 32'h0;
      axil.WSTRB = 4'hF;
      axil.AWVALID = 1'b1;
      axil.WVALID = 1'b1;
      mout.tready = 1'b1;
      @(negedge ACLK);
      chk("clr_wr_rdy", 32'(axil.AWREADY), 32'd1);
      chk("clr_m_tvalid", 32'(mout.tvalid), 32'd1);
      @(posedge ACLK);
      #1;
      axil.AWVALID = 1'b0;
      axil.WVALID = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      rd(4'hC, 32'h0);

      wr(4'h4, 32'h5, 4'hF);
      mout.tready = 1'b0;
      px(24'h222222, 1'b1, 24'h222222);
      axil.BREADY = 1'b0;
      axil.AWADDR = 4'h0;
      axil.WDATA = 32'h5;
      axil.WSTRB = 4'hF;
      axil.AWVALID = 1'b1;
      axil.WVALID = 1'b1;
      @(posedge ACLK);
      #1;
      axil.AWVALID = 1'b0;
      axil.WVALID = 1'b0;
      @(negedge ACLK);
      chk("pre_rst_bvalid", 32'(axil.BVALID), 32'd1);
      chk("pre_rst_m_tvalid", 32'(mout.tvalid), 32'd1);
      #1;
      ARESETN = 1'b0;
      #1;
      chk("mid_rst_m_tvalid", 32'(mout.tvalid), 32'd0);
      chk("mid_rst_bvalid", 32'(axil.BVALID), 32'd0);
      chk("mid_rst_m_tdata", 32'(mout.tdata), 32'd0);
      chk("mid_rst_s_tready", 32'(sin.tready), 32'd0);
      sq.delete();
      axil.BREADY = 1'b1;
      mout.tready = 1'b1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(posedge ACLK);
      #1;
      rd(4'h0, 32'h0);
      rd(4'h4, 32'h7);
      rd(4'hC, 32'h0);
      wr(4'h0, 32'h1, 4'hF);
      px(24'h123456, 1'b1, 24'h123456);
      drain();
      rd(4'hC, 32'h1);

      repeat (3) @(posedge ACLK);
      #1;
      chk("rq_empty", 32'(rq.size()), 32'd0);
      chk("sq_empty", 32'(sq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pixel_filter_axil.md
# pixel_filter_axil

Parametrised AXI4-Lite-configured pixel filter for the image-processing partial-reconfiguration region. It generalises the fixed single-colour filter IP: the channel count and channel width are parameters, and four filter modes are selected at run time. The block holds a four-register AXI4-Lite slave and a one-stage registered AXI4-Stream pixel pipeline. It sits between the video DMA read stream and the write-back stream, with its register slave on the PS general-purpose AXI port.

## Interface
- NUM_CHANNELS, 3: colour channels per pixel, 1..4.
- CHANNEL_WIDTH, 8: bits per channel, 4..16.
- C_S_AXI_DATA_WIDTH, 32: register bus width. Fixed at 32.
- C_S_AXI_ADDR_WIDTH, 4: register address width. Four word registers.
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  asynchronous active-low reset. Assertion is asynchronous; release is synchronous to ACLK.
- S_AXI_AW{ADDR,VALID,READY}, S_AXI_W{DATA,STRB,VALID,READY}, S_AXI_B{RESP,VALID,READY}, S_AXI_AR{ADDR,VALID,READY}, S_AXI_R{DATA,RESP,VALID,READY}: AXI4-Lite slave ports at the widths above. AWPROT/ARPROT are accepted and ignored.
- s_axis_tdata  in  NUM_CHANNELS*CHANNEL_WIDTH  input pixel. Channel k occupies bits [k*CW +: CW].
- s_axis_tvalid  in  1; s_axis_tready  out  1; s_axis_tlast  in  1.
- m_axis_tdata  out  NUM_CHANNELS*CHANNEL_WIDTH; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1.

## Operation
- Register map (byte addresses):
  - 0x0 CTRL: [0] EN, [2:1] MODE.
  - 0x4 MASK: [NUM_CHANNELS-1:0].
  - 0x8 THRESH: [CHANNEL_WIDTH-1:0].
  - 0xC PIXCNT: read-only count. Any write to it clears it.
- Unimplemented register bits read 0. WSTRB is honoured per byte. BRESP and RRESP are always OKAY.
- Reset values: CTRL=0, MASK=all ones, THRESH=0, PIXCNT=0.
- Filter function, applied per channel c with mask bit m:
  - EN=0: output = input (bypass).
  - MODE 0 (mask): out = m ? c : 0.
  - MODE 1 (threshold): out = (m && c >= THRESH) ? c : 0. Unsigned compare.
  - MODE 2 (invert): out = m ? ~c : c.
  - MODE 3 (dominant): a masked channel survives only if it is strictly greater than every other channel; otherwise out = 0. Unmasked channels → 0. Ties → all outputs 0.
- The configuration is sampled at the cycle the input pixel is accepted. A register write lands on the first pixel accepted after BVALID rises.
- tlast is passed through aligned with its pixel and is never altered.
- PIXCNT increments by 1 on every m_axis handshake (tvalid && tready). It wraps 0xFFFFFFFF→0.
- If a PIXCNT write and an increment fall in the same cycle, the clear wins: PIXCNT=0.

## Timing
- Write channel:
  - A write is accepted only when AWVALID && WVALID && !BVALID.
  - AWREADY and WREADY pulse high together for exactly one cycle.
  - The register updates on that edge.
  - BVALID rises the next cycle and holds until BREADY.
  - A lone AWVALID or a lone WVALID waits; it is not accepted alone.
- Read channel:
  - ARREADY pulses one cycle when ARVALID && !RVALID.
  - RVALID and RDATA appear the next cycle. RDATA stays stable until RREADY.
  - A read and a write in the same cycle are both serviced. A read returns the value held before the concurrent write's edge.
- Stream path:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready. Combinational; no bubble at full rate.
  - Latency is 1 cycle, input handshake to m_axis_tvalid.
  - Throughput is 1 pixel/cycle while m_axis_tready=1.
  - Under backpressure, m_axis_tdata and m_axis_tlast hold stable while tvalid=1 and tready=0.
  - m_axis_tvalid is never dropped before its handshake.
- Reset:
  - All outputs 0 during reset: READY/VALID signals, m_axis_tvalid, m_axis_tdata, RDATA, BRESP, RRESP.
  - s_axis_tready is low during reset and rises on the first cycle after release.
  - A reset mid-frame discards the in-flight pixel and any pending B or R response. All registers return to their reset values.

## Test plan
- Register round trip:
  - Write CTRL=0x5, MASK=0x6, THRESH=0x80, each with WSTRB=0xF. Read back 0x5, 0x6, 0x80.
  - Write MASK=0xFF with WSTRB=0x0, then read 0x6.
  - AW issued 3 cycles before W: a single BVALID appears after W arrives.
- Mask mode, 3×8 channels:
  - CTRL=0x1, MASK=0b100, input 0x30_20_10 → output 0x30_00_00.
  - EN=0 with the same input → output 0x30_20_10.
- Threshold and invert:
  - CTRL=0x3, MASK=0x7, THRESH=0x20, input 0x30_20_1F → 0x30_20_00.
  - CTRL=0x5, MASK=0b001, input 0x30_20_10 → 0x30_20_EF.
- Dominant mode:
  - CTRL=0x7, MASK=0x7, input 0x10_90_40 → 0x00_90_00.
  - Input 0x90_90_40 → 0x00_00_00.
- Backpressure and tlast:
  - Stream 16 pixels with the last marked by tlast, toggling m_axis_tready 1/0 every cycle.
  - Output order, data, and tlast must match the input exactly, and data must stay stable during stalls.
  - PIXCNT reads 16. Writing PIXCNT in the same cycle as a handshake leaves 0.
- Reset mid-operation:
  - Assert ARESETN low with m_axis_tvalid=1 and BVALID pending.
  - Same cycle: m_axis_tvalid=0, BVALID=0.
  - After release: CTRL=0, MASK=0x7, PIXCNT=0.
